vscale_hasti_arbiter: RTL and testbench

//  Two-master to one-slave HASTI (AHB-lite) arbiter. It sits directly upstream of the

---
 rtl/vscale_hasti_arbiter_pkg.sv | 42 ++++
 rtl/vscale_hasti_req_buf.sv | 46 ++++
 rtl/vscale_hasti_arbiter.sv | 149 ++++++++++++++
 tb/tb_vscale_hasti_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_hasti_arbiter_pkg.sv
// Shared HASTI encodings, request record and helpers for the two-master arbiter.
package vscale_hasti_arbiter_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_RESP_WIDTH  = 1;
  localparam int HASTI_MASTER_NUM  = 2;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE     = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALFWORD = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD     = 3'd2;

  localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_SINGLE = 3'd0;

  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

  // Address-phase fields that travel together through the buffer and the slave mux.
  typedef struct packed {
    logic [HASTI_ADDR_WIDTH-1:0]  haddr;
    logic                         hwrite;
    logic [HASTI_SIZE_WIDTH-1:0]  hsize;
    logic [HASTI_BURST_WIDTH-1:0] hburst;
    logic                         hmastlock;
    logic [HASTI_PROT_WIDTH-1:0]  hprot;
  } hasti_req_t;

  // SEQ and BUSY count as requests; only IDLE means no transfer.
  function automatic logic hasti_trans_active(input logic [HASTI_TRANS_WIDTH-1:0] htrans);
    return htrans != HASTI_TRANS_IDLE;
  endfunction

endpackage

// File: rtl/vscale_hasti_req_buf.sv
// One-entry capture/replay buffer for a single master plus the request mux
// that prefers the buffered request over the master's live bus.
module vscale_hasti_req_buf
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  hasti_req_t                   i_live,
  input  logic [HASTI_TRANS_WIDTH-1:0] i_htrans,
  input  logic                         i_hready,
  input  logic                         i_issue,
  output logic                         o_req_v,
  output hasti_req_t                   o_req,
  output logic                         o_pend_v
);

  logic       r_pend_v;
  hasti_req_t r_req;
  logic       w_live_v;
  logic       w_capture;

  assign w_live_v  = i_hready && hasti_trans_active(i_htrans);
  assign w_capture = !r_pend_v && w_live_v && !i_issue;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend_v <= 1'b0;
    end else if (i_issue) begin
      r_pend_v <= 1'b0;
    end else if (w_capture) begin
      r_pend_v <= 1'b1;
    end
  end

  // Payload only matters while r_pend_v is set, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      r_req <= i_live;
    end
  end

  assign o_req_v  = r_pend_v || w_live_v;
  assign o_req    = r_pend_v ? r_req : i_live;
  assign o_pend_v = r_pend_v;

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// Two-master to one-slave HASTI arbiter: per-master request buffers, round-robin or
// fixed-priority issue, and a data-phase tracker steering hwdata/hready/hresp.
module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
#(
  parameter logic FIXED_PRIORITY = 1'b0
) (
  input  logic                         hclk,
  input  logic                         reset,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
  input  logic                         m0_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m0_hburst,
  input  logic                         m0_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m0_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
  output logic                         m0_hready,
  output logic [HASTI_RESP_WIDTH-1:0]  m0_hresp,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
  input  logic                         m1_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m1_hburst,
  input  logic                         m1_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m1_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
  output logic                         m1_hready,
  output logic [HASTI_RESP_WIDTH-1:0]  m1_hresp,
  output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
  output logic                         s_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
  output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
  output logic                         s_hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
  output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
  input  logic                         s_hready,
  input  logic [HASTI_RESP_WIDTH-1:0]  s_hresp
);

  hasti_req_t                  w_live [HASTI_MASTER_NUM];
  hasti_req_t                  w_req  [HASTI_MASTER_NUM];
  logic [HASTI_MASTER_NUM-1:0] w_req_v;
  logic [HASTI_MASTER_NUM-1:0] w_pend_v;
  logic [HASTI_MASTER_NUM-1:0] w_hready;
  logic [HASTI_MASTER_NUM-1:0] w_own;
  logic [HASTI_MASTER_NUM-1:0] w_issue;
  logic                        w_any;
  logic                        w_gnt;

  logic r_rr;
  logic r_lock_v;
  logic r_lock_gnt;
  logic r_dph_v;
  logic r_dph_own;

  assign w_live[0] = '{haddr: m0_haddr, hwrite: m0_hwrite, hsize: m0_hsize,
                       hburst: m0_hburst, hmastlock: m0_hmastlock, hprot: m0_hprot};
  assign w_live[1] = '{haddr: m1_haddr, hwrite: m1_hwrite, hsize: m1_hsize,
                       hburst: m1_hburst, hmastlock: m1_hmastlock, hprot: m1_hprot};

  vscale_hasti_req_buf u_buf_m0 (
    .i_clk    (hclk),
    .i_rst    (reset),
    .i_live   (w_live[0]),
    .i_htrans (m0_htrans),
    .i_hready (w_hready[0]),
    .i_issue  (w_issue[0]),
    .o_req_v  (w_req_v[0]),
    .o_req    (w_req[0]),
    .o_pend_v (w_pend_v[0])
  );

  vscale_hasti_req_buf u_buf_m1 (
    .i_clk    (hclk),
    .i_rst    (reset),
    .i_live   (w_live[1]),
    .i_htrans (m1_htrans),
    .i_hready (w_hready[1]),
    .i_issue  (w_issue[1]),
    .o_req_v  (w_req_v[1]),
    .o_req    (w_req[1]),
    .o_pend_v (w_pend_v[1])
  );

  assign w_any = |w_req_v;

  // A stalled slave address phase keeps its winner even if the other master appears.
  always_comb begin
    w_gnt = 1'b0;
    if (r_lock_v) begin
      w_gnt = r_lock_gnt;
    end else if (w_req_v[0] && w_req_v[1]) begin
      w_gnt = FIXED_PRIORITY ? 1'b0 : r_rr;
    end else if (w_req_v[1]) begin
      w_gnt = 1'b1;
    end
  end

  assign w_issue[0] = s_hready && w_any && !w_gnt;
  assign w_issue[1] = s_hready && w_any &&  w_gnt;

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      r_rr       <= 1'b0;
      r_lock_v   <= 1'b0;
      r_lock_gnt <= 1'b0;
      r_dph_v    <= 1'b0;
      r_dph_own  <= 1'b0;
    end else if (s_hready) begin
      r_dph_v   <= w_any;
      r_dph_own <= w_gnt;
      r_lock_v  <= 1'b0;
      if (w_any) begin
        r_rr <= !w_gnt;
      end
    end else begin
      r_lock_v   <= w_any;
      r_lock_gnt <= w_gnt;
    end
  end

  assign s_htrans    = w_any ? HASTI_TRANS_NONSEQ : HASTI_TRANS_IDLE;
  assign s_haddr     = w_req[w_gnt].haddr;
  assign s_hwrite    = w_req[w_gnt].hwrite;
  assign s_hsize     = w_req[w_gnt].hsize;
  assign s_hburst    = w_req[w_gnt].hburst;
  assign s_hmastlock = w_req[w_gnt].hmastlock;
  assign s_hprot     = w_req[w_gnt].hprot;
  assign s_hwdata    = r_dph_own ? m1_hwdata : m0_hwdata;

  // Data-phase owner follows the slave; a master waiting on its buffer is held off.
  assign w_own[0]    = r_dph_v && !r_dph_own;
  assign w_own[1]    = r_dph_v &&  r_dph_own;
  assign w_hready[0] = w_own[0] ? s_hready : !w_pend_v[0];
  assign w_hready[1] = w_own[1] ? s_hready : !w_pend_v[1];

  assign m0_hready = w_hready[0];
  assign m1_hready = w_hready[1];
  assign m0_hresp  = w_own[0] ? s_hresp : HASTI_RESP_OKAY;
  assign m1_hresp  = w_own[1] ? s_hresp : HASTI_RESP_OKAY;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench for vscale_hasti_arbiter: vector table plus hand sequences,
// with a small word-addressed SRAM slave behind the round-robin instance.
module tb_vscale_hasti_arbiter;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] N = 2'd2;

  logic hclk;
  logic reset;

  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
  logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock, m0_hready, m1_hready;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hresp, m1_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite, s_hmastlock, s_hready, s_hresp;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;

  logic [31:0] f_m0_haddr, f_m1_haddr, f_m0_hrdata, f_m1_hrdata, f_s_haddr, f_s_hwdata;
  logic [1:0]  f_m0_htrans, f_m1_htrans, f_s_htrans;
  logic        f_m0_hready, f_m1_hready, f_m0_hresp, f_m1_hresp;
  logic        f_s_hwrite, f_s_hmastlock;
  logic [2:0]  f_s_hsize, f_s_hburst;
  logic [3:0]  f_s_hprot;

  int n_chk = 0;
  int n_fail = 0;

  vscale_hasti_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .hclk(hclk), .reset(reset),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  vscale_hasti_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .hclk(hclk), .reset(reset),
    .m0_haddr(f_m0_haddr), .m0_hwrite(1'b0), .m0_hsize(3'd2), .m0_hburst(3'd0),
    .m0_hmastlock(1'b0), .m0_hprot(4'd0), .m0_htrans(f_m0_htrans),
    .m0_hwdata(32'd0), .m0_hrdata(f_m0_hrdata), .m0_hready(f_m0_hready), .m0_hresp(f_m0_hresp),
    .m1_haddr(f_m1_haddr), .m1_hwrite(1'b0), .m1_hsize(3'd2), .m1_hburst(3'd0),
    .m1_hmastlock(1'b0), .m1_hprot(4'd0), .m1_htrans(f_m1_htrans),
    .m1_hwdata(32'd0), .m1_hrdata(f_m1_hrdata), .m1_hready(f_m1_hready), .m1_hresp(f_m1_hresp),
    .s_haddr(f_s_haddr), .s_hwrite(f_s_hwrite), .s_hsize(f_s_hsize), .s_hburst(f_s_hburst),
    .s_hmastlock(f_s_hmastlock), .s_hprot(f_s_hprot), .s_htrans(f_s_htrans),
    .s_hwdata(f_s_hwdata), .s_hrdata(32'd0), .s_hready(1'b1), .s_hresp(1'b0)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // SRAM slave: memory is preloaded with 0xA0000000 + word index.
  logic [31:0] mem [256];
  logic        sl_dv, sl_dw;
  logic [31:0] sl_da;
  logic [31:0] slog [$];

  assign s_hrdata = mem[sl_da[9:2]];
  assign s_hresp  = 1'b0;

  always @(posedge hclk or posedge reset) begin
    if (reset) begin
      sl_dv <= 1'b0;
      sl_dw <= 1'b0;
      sl_da <= 32'd0;
    end else if (s_hready) begin
      if (sl_dv && sl_dw) mem[sl_da[9:2]] <= s_hwdata;
      sl_dv <= (s_htrans != I);
      sl_dw <= s_hwrite;
      sl_da <= s_haddr;
      if (s_htrans != I) slog.push_back(s_haddr);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  t0;
    logic [31:0] a0;
    logic        w0;
    logic [31:0] d0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic        sr;
    logic [1:0]  est;
    logic [31:0] esa;
    logic        eh0;
    logic        eh1;
    logic        crd;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        dp, presented, h;
    logic [31:0] dpa, pa;
    int          idx, nrd, cyc;

    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    reset = 1'b1; s_hready = 1'b1;
    m0_haddr = 0; m0_hwrite = 0; m0_hsize = 3'd2; m0_hburst = 0; m0_hmastlock = 0;
    m0_hprot = 0; m0_htrans = I; m0_hwdata = 0;
    m1_haddr = 0; m1_hwrite = 0; m1_hsize = 3'd2; m1_hburst = 0; m1_hmastlock = 0;
    m1_hprot = 0; m1_htrans = I; m1_hwdata = 32'h1234_5678;
    f_m0_haddr = 0; f_m0_htrans = I; f_m1_haddr = 0; f_m1_htrans = I;

    //          t0 a0       w0 d0            t1 a1       sr  est a_exp    h0 h1 crd rd
    vecs[0]  = '{N, 32'h100, 1, 32'h0,        I, 32'h0,   1, N, 32'h100, 1, 1, 0, 32'h0};
    vecs[1]  = '{N, 32'h100, 0, 32'hDEADBEEF, I, 32'h0,   1, N, 32'h100, 1, 1, 0, 32'h0};
    vecs[2]  = '{I, 32'h0,   0, 32'hDEADBEEF, I, 32'h0,   1, I, 32'h0,   1, 1, 1, 32'hDEADBEEF};
    vecs[3]  = '{I, 32'h0,   0, 32'h0,        N, 32'h200, 1, N, 32'h200, 1, 1, 0, 32'h0};
    vecs[4]  = '{N, 32'h100, 0, 32'h0,        N, 32'h204, 1, N, 32'h100, 1, 1, 1, 32'hA0000080};
    vecs[5]  = '{I, 32'h0,   0, 32'h0,        I, 32'h0,   1, N, 32'h204, 1, 0, 1, 32'hDEADBEEF};
    vecs[6]  = '{I, 32'h0,   0, 32'h0,        I, 32'h0,   1, I, 32'h0,   1, 1, 1, 32'hA0000081};
    vecs[7]  = '{N, 32'h108, 1, 32'h0,        I, 32'h0,   1, N, 32'h108, 1, 1, 0, 32'h0};
    vecs[8]  = '{I, 32'h0,   0, 32'h11112222, N, 32'h100, 0, N, 32'h100, 0, 1, 0, 32'h0};
    vecs[9]  = '{I, 32'h0,   0, 32'h11112222, I, 32'h0,   0, N, 32'h100, 0, 0, 0, 32'h0};
    vecs[10] = '{I, 32'h0,   0, 32'h11112222, I, 32'h0,   1, N, 32'h100, 1, 0, 0, 32'h0};
    vecs[11] = '{I, 32'h0,   0, 32'h0,        I, 32'h0,   1, I, 32'h0,   1, 1, 1, 32'hDEADBEEF};
    vecs[12] = '{N, 32'h108, 0, 32'h0,        I, 32'h0,   1, N, 32'h108, 1, 1, 0, 32'h0};
    vecs[13] = '{I, 32'h0,   0, 32'h0,        I, 32'h0,   1, I, 32'h0,   1, 1, 1, 32'h11112222};

    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_htrans", 32'(s_htrans), 32'(I));
    check("rst_m0_hready", 32'(m0_hready), 32'd1);
    check("rst_m1_hready", 32'(m1_hready), 32'd1);
    check("rst_m0_hresp", 32'(m0_hresp), 32'd0);
    check("rst_hwdata", s_hwdata, m0_hwdata);
    @(posedge hclk); #1 reset = 1'b0;

    for (int v = 0; v < 14; v++) begin
      @(posedge hclk); #1;
      m0_htrans = vecs[v].t0; m0_haddr = vecs[v].a0; m0_hwrite = vecs[v].w0;
      m0_hwdata = vecs[v].d0; m1_htrans = vecs[v].t1; m1_haddr = vecs[v].a1;
      m1_hwrite = 1'b0; s_hready = vecs[v].sr;
      @(negedge hclk);
      check($sformatf("v%0d_htrans", v), 32'(s_htrans), 32'(vecs[v].est));
      if (vecs[v].est != I) check($sformatf("v%0d_haddr", v), s_haddr, vecs[v].esa);
      check($sformatf("v%0d_m0_hready", v), 32'(m0_hready), 32'(vecs[v].eh0));
      check($sformatf("v%0d_m1_hready", v), 32'(m1_hready), 32'(vecs[v].eh1));
      if (vecs[v].crd) begin
        check($sformatf("v%0d_m0_hrdata", v), m0_hrdata, vecs[v].erd);
        check($sformatf("v%0d_m1_hrdata", v), m1_hrdata, vecs[v].erd);
      end
    end

    // m1 streams four reads; m0 slips one write in alongside the second read.
    slog.delete();
    idx = 0; nrd = 0; cyc = 0; dp = 1'b0; dpa = 0;
    @(posedge hclk); #1;
    m0_htrans = I; m1_htrans = N; m1_haddr = 32'h300;
    while (nrd < 4 && cyc < 20) begin
      presented = (m1_htrans == N);
      pa = m1_haddr;
      @(negedge hclk);
      h = m1_hready;
      if (h) begin
        if (dp) begin
          check($sformatf("t3_rd_%0d", nrd), m1_hrdata, 32'hA000_0000 + (dpa >> 2));
          nrd++;
        end
        dp = presented;
        dpa = pa;
        if (presented) idx++;
      end
      @(posedge hclk); #1;
      cyc++;
      m1_htrans = (idx < 4) ? N : I;
      m1_haddr  = 32'h300 + 32'(4 * idx);
      if (cyc == 1) begin
        m0_htrans = N; m0_haddr = 32'h380; m0_hwrite = 1'b1;
      end else begin
        m0_htrans = I; m0_hwrite = 1'b0;
        if (cyc == 2) m0_hwdata = 32'h5555_AAAA;
      end
    end
    if (nrd < 4) check("t3_timeout", 32'(nrd), 32'd4);
    check("t3_count", 32'(slog.size()), 32'd5);
    if (slog.size() > 0) check("t3_order0", slog[0], 32'h300);
    if (slog.size() > 1) check("t3_order1", slog[1], 32'h380);
    if (slog.size() > 2) check("t3_order2", slog[2], 32'h304);
    if (slog.size() > 3) check("t3_order3", slog[3], 32'h308);
    if (slog.size() > 4) check("t3_order4", slog[4], 32'h30C);
    check("t3_wr_mem", mem[32'h380 >> 2], 32'h5555_AAAA);

    // Reset while m1 is buffered and m0 owns the data phase.
    @(posedge hclk); #1;
    m0_htrans = N; m0_haddr = 32'h100; m1_htrans = N; m1_haddr = 32'h200;
    @(negedge hclk);
    check("t5_win_m0", s_haddr, 32'h100);
    @(posedge hclk); #1;
    m0_htrans = I; m1_htrans = I; m0_hwdata = 32'h0BAD_0000;
    @(negedge hclk);
    check("t5_m1_pend", 32'(m1_hready), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_htrans", 32'(s_htrans), 32'(I));
    check("t5_rst_m0_hready", 32'(m0_hready), 32'd1);
    check("t5_rst_m1_hready", 32'(m1_hready), 32'd1);
    check("t5_rst_hwdata", s_hwdata, 32'h0BAD_0000);
    @(posedge hclk); #1 reset = 1'b0;
    @(negedge hclk);
    check("t5_post_htrans", 32'(s_htrans), 32'(I));
    check("t5_post_m1_hready", 32'(m1_hready), 32'd1);
    @(posedge hclk); #1;
    m0_htrans = N; m0_haddr = 32'h100; m1_htrans = N; m1_haddr = 32'h204;
    @(negedge hclk);
    check("t5_rr_reset", s_haddr, 32'h100);
    @(posedge hclk); #1;
    m0_htrans = I; m1_htrans = I;
    @(negedge hclk);
    check("t5_m1_addr", s_haddr, 32'h204);
    check("t5_m1_wait", 32'(m1_hready), 32'd0);
    check("t5_m0_rd", m0_hrdata, 32'hDEADBEEF);
    @(posedge hclk); #1;
    @(negedge hclk);
    check("t5_m1_done", 32'(m1_hready), 32'd1);
    check("t5_m1_rd", m1_hrdata, 32'hA000_0081);

    // Fixed priority: m0 continuous starves m1 until it goes idle.
    for (int c = 0; c < 4; c++) begin
      @(posedge hclk); #1;
      f_m0_htrans = N; f_m0_haddr = 32'h10 + 32'(4 * c);
      f_m1_htrans = N; f_m1_haddr = 32'h20;
      @(negedge hclk);
      check($sformatf("t6_haddr_%0d", c), f_s_haddr, 32'h10 + 32'(4 * c));
      check($sformatf("t6_m1_hready_%0d", c), 32'(f_m1_hready), (c == 0) ? 32'd1 : 32'd0);
    end
    @(posedge hclk); #1;
    f_m0_htrans = I;
    @(negedge hclk);
    check("t6_m1_issue", f_s_haddr, 32'h20);
    check("t6_m1_wait", 32'(f_m1_hready), 32'd0);
    @(posedge hclk); #1;
    f_m1_htrans = I;
    @(negedge hclk);
    check("t6_m1_done", 32'(f_m1_hready), 32'd1);
    check("t6_idle", 32'(f_s_htrans), 32'(I));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
